// File: rtl/plic_src_filter.sv
`default_nettype none
// ============================================================================
// Module      : plic_src_filter
// Description : Per-source interrupt input conditioning for the PLIC.
//               Two-flop synchronizer, polarity correction, optional
//               debounce filter and a toggle-detect pulse per source.
//               Optional feature macro: PLIC_SRC_FILTER_EN
//                 defined   -> per-source debounce counters are built
//                 undefined -> filtered bit follows the sample every edge
// Revision    : 1.0 - initial release
// ============================================================================
module plic_src_filter #(
    parameter int SOURCES     = 8,
    parameter int FILTER_BITS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SOURCES-1:0]     src_raw,
    input  logic [SOURCES-1:0]     pol,
    input  logic [FILTER_BITS-1:0] filt_len,
    output logic [SOURCES-1:0]     src,
    output logic [SOURCES-1:0]     chg
);

    logic [SOURCES-1:0] r_s1;
    logic [SOURCES-1:0] r_s2;
    logic [1:0]         r_vld;
    logic [SOURCES-1:0] r_filt_d;
    logic [SOURCES-1:0] w_sample;
    logic [SOURCES-1:0] w_filt;

    // Polarity-corrected sample; a pol change takes effect immediately.
    assign w_sample = r_s2 ^ pol;

    // Two-flop synchronizer plus a warm-up flag: the synchronizer holds no
    // real sample until two edges after reset, so the filter waits for it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1  <= '0;
            r_s2  <= '0;
            r_vld <= 2'b00;
        end else begin
            r_s1  <= src_raw;
            r_s2  <= r_s1;
            r_vld <= {r_vld[0], 1'b1};
        end
    end

`ifdef PLIC_SRC_FILTER_EN
    // One debounce counter per source; filt_len is read fresh every edge so
    // lowering it below a running count releases the update at once.
    for (genvar s = 0; s < SOURCES; s++) begin : g_src
        logic                   r_bit;
        logic [FILTER_BITS-1:0] r_cnt;

        // Debounce: count consecutive differing samples, commit at filt_len.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_bit <= 1'b0;
                r_cnt <= '0;
            end else if (r_vld[1]) begin
                if (w_sample[s] == r_bit) begin
                    r_cnt <= '0;
                end else if (r_cnt >= filt_len) begin
                    r_bit <= w_sample[s];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_filt[s] = r_bit;
    end : g_src
`else
    logic [SOURCES-1:0] r_filt;
    // Debounce length has no effect without the filter; port is kept.
    logic               w_unused_filt_len;
    assign w_unused_filt_len = ^filt_len;

    // No filter: the filtered bit tracks the synchronized sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt <= '0;
        end else if (r_vld[1]) begin
            r_filt <= w_sample;
        end
    end

    assign w_filt = r_filt;
`endif

    // Previous filtered value, used to flag a toggle for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt_d <= '0;
        end else begin
            r_filt_d <= w_filt;
        end
    end

    assign src = w_filt;
    assign chg = w_filt ^ r_filt_d;

endmodule : plic_src_filter
`default_nettype wire

// File: tb/tb_plic_src_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_plic_src_filter
// Description : Directed bench for plic_src_filter. A vector table with
//               filt_len = 0 (same behaviour with or without the filter),
//               then hand-written multi-cycle sequences that depend on
//               whether PLIC_SRC_FILTER_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_plic_src_filter;

    logic       clk;
    logic       rst;
    logic [7:0] src_raw;
    logic [7:0] pol;
    logic [3:0] filt_len;
    logic [7:0] src;
    logic [7:0] chg;

    int n_vec;
    int n_err;

    plic_src_filter #(
        .SOURCES    (8),
        .FILTER_BITS(4)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .src_raw (src_raw),
        .pol     (pol),
        .filt_len(filt_len),
        .src     (src),
        .chg     (chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] raw;
        logic [7:0] pol;
        logic [7:0] exp_src;
        logic [7:0] exp_chg;
    } vec_t;

    vec_t tbl[24];

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] es, input logic [7:0] ec);
        n_vec++;
        if (src !== es || chg !== ec) begin
            n_err++;
            $display("FAIL %s: src=%h chg=%h expected src=%h chg=%h", nm, src, chg, es, ec);
        end
    endtask

    task automatic do_reset();
        src_raw = 8'h00;
        pol     = 8'h00;
        rst     = 1'b1;
        tick();
        chk("reset", 8'h00, 8'h00);
        rst = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        src_raw  = 8'h00;
        pol      = 8'h00;
        filt_len = 4'd0;

        //           rst   raw    pol    src    chg
        tbl[0]  = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[1]  = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[2]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[3]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[4]  = '{1'b0, 8'hA5, 8'h00, 8'h00, 8'h00};
        tbl[5]  = '{1'b0, 8'hA5, 8'h00, 8'h00, 8'h00};
        tbl[6]  = '{1'b0, 8'hA5, 8'h00, 8'hA5, 8'hA5};
        tbl[7]  = '{1'b0, 8'hA5, 8'h00, 8'hA5, 8'h00};
        tbl[8]  = '{1'b0, 8'h5A, 8'h00, 8'hA5, 8'h00};
        tbl[9]  = '{1'b0, 8'h5A, 8'h00, 8'hA5, 8'h00};
        tbl[10] = '{1'b0, 8'h5A, 8'h00, 8'h5A, 8'hFF};
        tbl[11] = '{1'b0, 8'h5A, 8'h00, 8'h5A, 8'h00};
        tbl[12] = '{1'b0, 8'h5A, 8'h0F, 8'h55, 8'h0F};
        tbl[13] = '{1'b0, 8'h5A, 8'h0F, 8'h55, 8'h00};
        tbl[14] = '{1'b0, 8'hDA, 8'h0F, 8'h55, 8'h00};
        tbl[15] = '{1'b0, 8'h5A, 8'h0F, 8'h55, 8'h00};
        tbl[16] = '{1'b0, 8'h5A, 8'h0F, 8'hD5, 8'h80};
        tbl[17] = '{1'b0, 8'h5A, 8'h0F, 8'h55, 8'h80};
        tbl[18] = '{1'b0, 8'h5A, 8'h0F, 8'h55, 8'h00};
        tbl[19] = '{1'b1, 8'h5A, 8'h0F, 8'h00, 8'h00};
        tbl[20] = '{1'b0, 8'h5A, 8'h0F, 8'h00, 8'h00};
        tbl[21] = '{1'b0, 8'h5A, 8'h0F, 8'h00, 8'h00};
        tbl[22] = '{1'b0, 8'h5A, 8'h0F, 8'h55, 8'h55};
        tbl[23] = '{1'b0, 8'h5A, 8'h0F, 8'h55, 8'h00};

        for (int i = 0; i < 24; i++) begin
            rst     = tbl[i].rst;
            src_raw = tbl[i].raw;
            pol     = tbl[i].pol;
            tick();
            chk($sformatf("tbl[%0d]", i), tbl[i].exp_src, tbl[i].exp_chg);
        end

`ifdef PLIC_SRC_FILTER_EN
        // Long rise on source 0 with filt_len = 3: src after E+5 only.
        do_reset();
        filt_len = 4'd3;
        src_raw  = 8'h01;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("rise_wait%0d", k), 8'h00, 8'h00);
        end
        tick();
        chk("rise_hit", 8'h01, 8'h01);
        tick();
        chk("rise_hold", 8'h01, 8'h00);

        // Three-cycle glitch on source 1 is swallowed; a later rise then
        // shows full latency, proving the count went back to zero.
        do_reset();
        filt_len = 4'd3;
        src_raw  = 8'h02;
        tick();
        chk("glitch_e0", 8'h00, 8'h00);
        tick();
        tick();
        src_raw = 8'h00;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("glitch_quiet%0d", k), 8'h00, 8'h00);
        end
        src_raw = 8'h02;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("after_glitch%0d", k), 8'h00, 8'h00);
        end
        tick();
        chk("after_glitch_hit", 8'h02, 8'h02);

        // filt_len lowered from 15 to 4 while count on source 3 sits at 8.
        do_reset();
        filt_len = 4'd15;
        src_raw  = 8'h08;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("len15_wait%0d", k), 8'h00, 8'h00);
        end
        filt_len = 4'd4;
        tick();
        chk("len_drop_hit", 8'h08, 8'h08);

        // Reset mid-count on source 4 discards the count.
        do_reset();
        filt_len = 4'd3;
        src_raw  = 8'h10;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("pre_rst%0d", k), 8'h00, 8'h00);
        end
        rst = 1'b1;
        tick();
        chk("mid_rst", 8'h00, 8'h00);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("post_rst%0d", k), 8'h00, 8'h00);
        end
        tick();
        chk("post_rst_hit", 8'h10, 8'h10);
`else
        // Without the filter, filt_len has no effect: a one-cycle pulse
        // passes straight through with two-edge latency.
        do_reset();
        filt_len = 4'd15;
        src_raw  = 8'h40;
        tick();
        chk("nf_e0", 8'h00, 8'h00);
        src_raw = 8'h00;
        tick();
        chk("nf_e1", 8'h00, 8'h00);
        tick();
        chk("nf_e2", 8'h40, 8'h40);
        tick();
        chk("nf_e3", 8'h00, 8'h40);
        tick();
        chk("nf_e4", 8'h00, 8'h00);
        src_raw = 8'hFF;
        tick();
        chk("nf_all_e0", 8'h00, 8'h00);
        tick();
        chk("nf_all_e1", 8'h00, 8'h00);
        tick();
        chk("nf_all_e2", 8'hFF, 8'hFF);
        tick();
        chk("nf_all_e3", 8'hFF, 8'h00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_plic_src_filter
`default_nettype wire
